// File: rtl/win_avg_diff_pkg.sv
// Shared types, mode constants and arithmetic helpers for the windowed averager.
// Imported by win_avg_diff and win_avg_hist.
package win_avg_pkg;

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        STEADY = 1'b1
    } state_t;

    localparam int MODE_BLOCK = 0;
    localparam int MODE_SLIDE = 1;

    // Operand width of abs_diff; callers zero-extend W-bit values into it.
    localparam int ABS_W = 32;

    function automatic logic [ABS_W-1:0] abs_diff(
        input logic [ABS_W-1:0] a,
        input logic [ABS_W-1:0] b
    );
        logic [ABS_W-1:0] r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = b - a;
        end
        return r;
    endfunction

endpackage

// File: rtl/win_avg_hist.sv
// N x W sample history ring. The slot under the write pointer is always the
// oldest stored sample, i.e. the one the next write will replace.
module win_avg_hist
    import win_avg_pkg::*;
#(
    parameter int W     = 8,
    parameter int LOG2N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    output logic [W-1:0] o_oldest
);

    localparam int N = 1 << LOG2N;

    logic [W-1:0]     r_mem [N];
    logic [LOG2N-1:0] r_wptr;

    // Write pointer, wraps modulo N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= {LOG2N{1'b0}};
        end else if (clr) begin
            r_wptr <= {LOG2N{1'b0}};
        end else if (i_wr_en) begin
            r_wptr <= r_wptr + LOG2N'(1);
        end else begin
            r_wptr <= r_wptr;
        end
    end

    // Sample storage, cleared on reset and flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_mem[i] <= {W{1'b0}};
            end
        end else if (clr) begin
            for (int i = 0; i < N; i++) begin
                r_mem[i] <= {W{1'b0}};
            end
        end else if (i_wr_en) begin
            r_mem[r_wptr] <= i_wr_data;
        end else begin
            r_mem[r_wptr] <= r_mem[r_wptr];
        end
    end

    assign o_oldest = r_mem[r_wptr];

endmodule

// File: rtl/win_avg_diff.sv
// Windowed mean of N = 2**LOG2N samples plus |mean - newest sample|, block or
// sliding mode. Define AVG_ROUND_EN for round-half-up averaging (default truncates).
module win_avg_diff
    import win_avg_pkg::*;
#(
    parameter int W     = 8,
    parameter int LOG2N = 2,
    parameter int MODE  = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] avg_out,
    output logic [W-1:0] diff_out,
    output logic         done
);

    localparam int N  = 1 << LOG2N;
    localparam int AW = W + LOG2N;
    localparam logic [LOG2N-1:0] CNT_LAST = {LOG2N{1'b1}};

`ifdef AVG_ROUND_EN
    localparam logic [AW-1:0] ROUND_BIAS = AW'(N / 2);
`else
    localparam logic [AW-1:0] ROUND_BIAS = {AW{1'b0}};
`endif

    logic             r_out_valid;
    logic [W-1:0]     r_avg_out;
    logic [W-1:0]     r_diff_out;
    logic             r_done;
    logic [AW-1:0]    r_acc;
    logic [LOG2N-1:0] r_count;
    state_t           r_state;

    logic             w_in_ready;
    logic             w_fire;
    logic             w_drain;
    logic             w_last;
    logic [W-1:0]     w_oldest;
    logic [AW-1:0]    w_sample;
    logic [AW-1:0]    w_sum_add;
    logic [AW-1:0]    w_sum_slide;
    logic [AW-1:0]    w_acc_nxt;
    logic [AW-1:0]    w_res_sum;
    logic [LOG2N-1:0] w_count_nxt;
    state_t           w_state_nxt;
    logic             w_emit;
    logic             w_done_nxt;
    logic [W-1:0]     w_avg;
    logic [W-1:0]     w_diff;

    // A held result blocks intake unless it drains this cycle.
    assign w_in_ready = !clr && !(r_out_valid && !out_ready);
    assign w_fire     = in_valid && w_in_ready;
    assign w_drain    = r_out_valid && out_ready;
    assign w_last     = (r_count == CNT_LAST);

    // The window sum fits AW bits, so modular add-then-subtract is exact.
    assign w_sample    = AW'(in_data);
    assign w_sum_add   = r_acc + w_sample;
    assign w_sum_slide = r_acc + w_sample - AW'(w_oldest);

    generate
        if (MODE == MODE_SLIDE) begin : g_hist
            win_avg_hist #(
                .W     (W),
                .LOG2N (LOG2N)
            ) u_hist (
                .clk       (clk),
                .rst_n     (rst_n),
                .clr       (clr),
                .i_wr_en   (w_fire),
                .i_wr_data (in_data),
                .o_oldest  (w_oldest)
            );
        end else begin : g_no_hist
            assign w_oldest = {W{1'b0}};
        end
    endgenerate

    // Next window state and whether this accept completes a result.
    always_comb begin
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_res_sum   = w_sum_add;
        if (clr) begin
            w_acc_nxt   = {AW{1'b0}};
            w_count_nxt = {LOG2N{1'b0}};
            w_state_nxt = FILL;
        end else if (w_fire) begin
            if ((MODE == MODE_SLIDE) && (r_state == STEADY)) begin
                w_acc_nxt = w_sum_slide;
                w_res_sum = w_sum_slide;
                w_emit    = 1'b1;
            end else if (w_last) begin
                w_emit      = 1'b1;
                w_res_sum   = w_sum_add;
                w_count_nxt = {LOG2N{1'b0}};
                if (MODE == MODE_SLIDE) begin
                    w_acc_nxt   = w_sum_add;
                    w_state_nxt = STEADY;
                end else begin
                    w_acc_nxt   = {AW{1'b0}};
                    w_state_nxt = FILL;
                end
            end else begin
                w_acc_nxt   = w_sum_add;
                w_count_nxt = r_count + LOG2N'(1);
            end
        end else begin
            w_acc_nxt = r_acc;
        end
    end

    assign w_done_nxt = (w_state_nxt == FILL) && (w_count_nxt == {LOG2N{1'b0}});
    assign w_avg      = W'((w_res_sum + ROUND_BIAS) >> LOG2N);
    assign w_diff     = W'(abs_diff(ABS_W'(w_avg), ABS_W'(in_data)));

    // Window bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= {AW{1'b0}};
            r_count <= {LOG2N{1'b0}};
            r_state <= FILL;
            r_done  <= 1'b1;
        end else begin
            r_acc   <= w_acc_nxt;
            r_count <= w_count_nxt;
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Result register; a new result may load in the same cycle the old one drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_avg_out   <= {W{1'b0}};
            r_diff_out  <= {W{1'b0}};
        end else if (clr) begin
            r_out_valid <= 1'b0;
            r_avg_out   <= r_avg_out;
            r_diff_out  <= r_diff_out;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
            r_avg_out   <= w_avg;
            r_diff_out  <= w_diff;
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
            r_avg_out   <= r_avg_out;
            r_diff_out  <= r_diff_out;
        end else begin
            r_out_valid <= r_out_valid;
            r_avg_out   <= r_avg_out;
            r_diff_out  <= r_diff_out;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign avg_out   = r_avg_out;
    assign diff_out  = r_diff_out;
    assign done      = r_done;

endmodule

// File: tb/tb_win_avg_diff.sv
// Bench for win_avg_diff: a block-mode and a sliding-mode instance checked
// against a queue-based window model.
module tb_win_avg_diff;

    localparam int W     = 8;
    localparam int LOG2N = 2;
    localparam int N     = 1 << LOG2N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [1:0]          clr_i;
    logic [1:0]          iv;
    logic [1:0]          ir;
    logic [1:0]          ov;
    logic [1:0]          orr;
    logic [1:0]          dn;
    logic [1:0][W-1:0]   id;
    logic [1:0][W-1:0]   avg;
    logic [1:0][W-1:0]   dif;

    int n_tests = 0;
    int n_fail  = 0;
    int q [2][$];

    win_avg_diff #(.W(W), .LOG2N(LOG2N), .MODE(0)) u_blk (
        .clk(clk), .rst_n(rst_n), .clr(clr_i[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(id[0]), .out_valid(ov[0]), .out_ready(orr[0]), .avg_out(avg[0]),
        .diff_out(dif[0]), .done(dn[0])
    );

    win_avg_diff #(.W(W), .LOG2N(LOG2N), .MODE(1)) u_sld (
        .clk(clk), .rst_n(rst_n), .clr(clr_i[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(id[1]), .out_valid(ov[1]), .out_ready(orr[1]), .avg_out(avg[1]),
        .diff_out(dif[1]), .done(dn[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: m=0 averages disjoint groups of N, m=1 the last N samples.
    task automatic model_accept(input int m, input int d, output bit emit,
                                output int ea, output int ed);
        int sum;
        q[m].push_back(d);
        if (m == 1 && q[m].size() > N) void'(q[m].pop_front());
        emit = (q[m].size() == N);
        sum = 0;
        foreach (q[m][i]) sum += q[m][i];
`ifdef AVG_ROUND_EN
        ea = (sum + N / 2) / N;
`else
        ea = sum / N;
`endif
        ed = (ea >= d) ? ea - d : d - ea;
        if (m == 0 && emit) q[m].delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; drives one sample, waits for acceptance, checks the result edge.
    task automatic push(input int m, input int d);
        int t;
        bit e;
        int ea, ed;
        iv[m] = 1'b1;
        id[m] = W'(d);
        t = 0;
        #1;
        while (!ir[m] && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("accept_wait", 32'(t < 50), 32'(1));
        @(posedge clk);
        #1;
        iv[m] = 1'b0;
        model_accept(m, d, e, ea, ed);
        chk("out_valid", 32'(ov[m]), 32'(e));
        if (e) begin
            chk("avg", 32'(avg[m]), 32'(ea));
            chk("diff", 32'(dif[m]), 32'(ed));
        end
        chk("done", 32'(dn[m]), 32'(q[m].size() == 0));
        @(negedge clk);
    endtask

    // clr together with a valid sample: the sample must be dropped.
    task automatic do_clr(input int m);
        clr_i[m] = 1'b1;
        iv[m]    = 1'b1;
        id[m]    = W'(8'd99);
        #1;
        chk("clr_in_ready", 32'(ir[m]), 32'(0));
        @(posedge clk);
        #1;
        clr_i[m] = 1'b0;
        iv[m]    = 1'b0;
        q[m].delete();
        chk("clr_out_valid", 32'(ov[m]), 32'(0));
        chk("clr_done", 32'(dn[m]), 32'(1));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit e;
        int ea, ed, ea_prev;
        rst_n = 1'b1;
        clr_i = 2'b00;
        iv    = 2'b00;
        id    = '0;
        orr   = 2'b11;
        #2 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("rst_out_valid", 32'(ov[m]), 32'(0));
            chk("rst_avg", 32'(avg[m]), 32'(0));
            chk("rst_diff", 32'(dif[m]), 32'(0));
            chk("rst_done", 32'(dn[m]), 32'(1));
            chk("rst_in_ready", 32'(ir[m]), 32'(1));
        end
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Block mode directed windows.
        push(0, 10); push(0, 20); push(0, 30); push(0, 40);
        push(0, 255); push(0, 255); push(0, 255); push(0, 255);
        push(0, 0); push(0, 0); push(0, 0); push(0, 200);
        push(0, 1); push(0, 1); push(0, 2); push(0, 2);

        // Sliding mode: no result for the first three samples.
        push(1, 4); push(1, 8); push(1, 12); push(1, 16); push(1, 20);

        // Block backpressure: completed result held, next sample stalls.
        idle(1);
        orr[0] = 1'b0;
        push(0, 5); push(0, 6); push(0, 7); push(0, 8);
        ea_prev = (5 + 6 + 7 + 8) / N;
`ifdef AVG_ROUND_EN
        ea_prev = (5 + 6 + 7 + 8 + N / 2) / N;
`endif
        idle(2);
        #1;
        chk("bp_held_valid", 32'(ov[0]), 32'(1));
        chk("bp_held_avg", 32'(avg[0]), 32'(ea_prev));
        chk("bp_in_ready", 32'(ir[0]), 32'(0));
        iv[0] = 1'b1;
        id[0] = W'(9);
        @(posedge clk);
        #1;
        chk("bp_stall_valid", 32'(ov[0]), 32'(1));
        chk("bp_stall_done", 32'(dn[0]), 32'(1));
        @(negedge clk);
        orr[0] = 1'b1;
        #1;
        chk("bp_release_ready", 32'(ir[0]), 32'(1));
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        model_accept(0, 9, e, ea, ed);
        chk("bp_drained", 32'(ov[0]), 32'(e));
        chk("bp_taken_done", 32'(dn[0]), 32'(0));
        @(negedge clk);
        push(0, 10); push(0, 11); push(0, 12);

        // Sliding pass-through: drain and new completion on the same edge.
        idle(1);
        orr[1] = 1'b0;
        push(1, 24);
        iv[1] = 1'b1;
        id[1] = W'(28);
        #1;
        chk("pt_stall_ready", 32'(ir[1]), 32'(0));
        @(negedge clk);
        orr[1] = 1'b1;
        #1;
        chk("pt_release_ready", 32'(ir[1]), 32'(1));
        @(posedge clk);
        #1;
        iv[1] = 1'b0;
        model_accept(1, 28, e, ea, ed);
        chk("pt_valid", 32'(ov[1]), 32'(e));
        chk("pt_avg", 32'(avg[1]), 32'(ea));
        chk("pt_diff", 32'(dif[1]), 32'(ed));
        @(negedge clk);

        // clr mid-window drops the sample and restarts the block.
        push(0, 7); push(0, 9);
        do_clr(0);
        push(0, 1); push(0, 2); push(0, 3); push(0, 6);
        do_clr(1);
        push(1, 50); push(1, 60); push(1, 70); push(1, 80); push(1, 90);

        // Asynchronous reset with results pending in both instances.
        idle(1);
        orr = 2'b00;
        push(0, 100); push(0, 110); push(0, 120); push(0, 130);
        push(1, 33);
        #2 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("arst_out_valid", 32'(ov[m]), 32'(0));
            chk("arst_avg", 32'(avg[m]), 32'(0));
            chk("arst_diff", 32'(dif[m]), 32'(0));
            chk("arst_done", 32'(dn[m]), 32'(1));
        end
        @(negedge clk);
        rst_n = 1'b1;
        q[0].delete();
        q[1].delete();
        orr = 2'b11;
        push(1, 3); push(1, 5); push(1, 7); push(1, 9); push(1, 11);
        push(0, 40); push(0, 41); push(0, 42); push(0, 43);

        // Randomised traffic with occasional gaps and flushes.
        for (int i = 0; i < 120; i++) begin
            int m;
            m = int'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                do_clr(m);
            end else begin
                push(m, int'($urandom_range(0, 255)));
            end
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
